solar_stepper_drv: RTL and testbench

//  Downstream of the solar tracker decision block. Consumes its per-direction motor requests
//  (mn/me/ms/mw) and drives two 4-phase wave-drive stepper motors.

---
 rtl/solar_pkg.sv | 35 +++
 rtl/stepper_axis.sv | 184 ++++++++++++++++++
 rtl/solar_stepper_drv.sv | 85 ++++++++
 tb/tb_solar_stepper_drv.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/solar_pkg.sv
// Shared types and helpers for the solar stepper driver.
//   axis_state_e : per-axis FSM state (OFF, DEB, RUN, HOLD)
//   dir_e        : decoded request direction (NONE, FWD, REV)
//   decode_dir   : {fwd,rev} request pair to dir_e; a conflict (11) reads as NONE
//   idx_to_phase : 2-bit phase index to 4-bit one-hot coil pattern
package solar_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_DEB  = 2'd1,
      ST_RUN  = 2'd2,
      ST_HOLD = 2'd3
   } axis_state_e;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_FWD  = 2'd1,
      DIR_REV  = 2'd2
   } dir_e;

   function automatic dir_e decode_dir(input logic fwd, input logic rev);
      dir_e d;
      case ({fwd, rev})
         2'b10:   d = DIR_FWD;
         2'b01:   d = DIR_REV;
         default: d = DIR_NONE;
      endcase
      return d;
   endfunction

   function automatic logic [3:0] idx_to_phase(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: request debounce, step pacing, soft-limited position,
// and coil de-energize after idle.
//   clk, rst   : clock, synchronous active-high reset
//   fwd, rev   : direction requests (both high = no request)
//   phase      : registered wave-drive coil pattern, one-hot or 0000
//   pos        : registered step position
//   lim        : registered, request blocked by a soft limit this cycle
//   run_nxt    : next-state is RUN (lets the top register busy in step with state)
module stepper_axis
   import solar_pkg::*;
#(
   parameter int unsigned DEB_CYC  = 4,
   parameter int unsigned STEP_DIV = 8,
   parameter int unsigned HOLD_CYC = 16,
   parameter int unsigned POS_W    = 8,
   parameter int unsigned POS_MAX  = 200,
   parameter int unsigned POS_HOME = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fwd,
   input  logic             rev,
   output logic [3:0]       phase,
   output logic [POS_W-1:0] pos,
   output logic             lim,
   output logic             run_nxt
);

   localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
   localparam int unsigned STEP_W = $clog2(STEP_DIV + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [POS_W-1:0]  POS_TOP   = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0]  POS_RST   = POS_W'(POS_HOME);

   axis_state_e       state_q, state_d;
   dir_e              dir_q, dir_d;
   logic              prior_hold_q, prior_hold_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [3:0]        phase_q, phase_d;
   logic              lim_q, lim_d;

   dir_e req;
   logic blocked;

   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      prior_hold_d = prior_hold_q;
      deb_cnt_d    = deb_cnt_q;
      step_cnt_d   = step_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      idx_d        = idx_q;
      pos_d        = pos_q;
      phase_d      = phase_q;
      lim_d        = 1'b0;
      req          = decode_dir(fwd, rev);
      blocked      = ((dir_q == DIR_FWD) && (pos_q == POS_TOP)) ||
                     ((dir_q == DIR_REV) && (pos_q == '0));

      case (state_q)
         ST_OFF: begin
            phase_d = '0;
            if (req != DIR_NONE) begin
               state_d      = ST_DEB;
               dir_d        = req;
               deb_cnt_d    = DEB_W'(1);
               prior_hold_d = 1'b0;
            end
         end

         ST_DEB: begin
            // prior_hold remembers whether coils were energized on entry,
            // so an abandoned debounce falls back to HOLD rather than OFF.
            if (req == DIR_NONE) begin
               if (prior_hold_q) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = '0;
               end else begin
                  state_d = ST_OFF;
                  phase_d = '0;
               end
            end else if (req != dir_q) begin
               dir_d     = req;
               deb_cnt_d = DEB_W'(1);
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d    = ST_RUN;
               phase_d    = idx_to_phase(idx_q);
               step_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
         end

         ST_RUN: begin
            if (req == DIR_NONE) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end else if (req != dir_q) begin
               state_d      = ST_DEB;
               dir_d        = req;
               deb_cnt_d    = DEB_W'(1);
               prior_hold_d = 1'b1;
            end else begin
               // Pacing keeps running while blocked; only the step itself is dropped.
               lim_d = blocked;
               if (step_cnt_q == STEP_LAST) begin
                  step_cnt_d = '0;
                  if (!blocked) begin
                     if (dir_q == DIR_FWD) begin
                        idx_d = idx_q + 2'd1;
                        pos_d = pos_q + POS_W'(1);
                     end else begin
                        idx_d = idx_q - 2'd1;
                        pos_d = pos_q - POS_W'(1);
                     end
                     phase_d = idx_to_phase(idx_d);
                  end
               end else begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
            end
         end

         ST_HOLD: begin
            if (req != DIR_NONE) begin
               state_d      = ST_DEB;
               dir_d        = req;
               deb_cnt_d    = DEB_W'(1);
               prior_hold_d = 1'b1;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_OFF;
               phase_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end

         default: begin
            state_d = ST_OFF;
            phase_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_OFF;
         dir_q        <= DIR_NONE;
         prior_hold_q <= 1'b0;
         deb_cnt_q    <= '0;
         step_cnt_q   <= '0;
         hold_cnt_q   <= '0;
         idx_q        <= '0;
         pos_q        <= POS_RST;
         phase_q      <= '0;
         lim_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         prior_hold_q <= prior_hold_d;
         deb_cnt_q    <= deb_cnt_d;
         step_cnt_q   <= step_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         idx_q        <= idx_d;
         pos_q        <= pos_d;
         phase_q      <= phase_d;
         lim_q        <= lim_d;
      end
   end

   assign phase   = phase_q;
   assign pos     = pos_q;
   assign lim     = lim_q;
   assign run_nxt = (state_d == ST_RUN);

endmodule

// File: rtl/solar_stepper_drv.sv
// Dual-axis wave-drive stepper driver fed by the solar tracker's direction requests.
//   clk, rst           : clock, synchronous active-high reset
//   mn, ms             : elevation forward / reverse request
//   me, mw             : azimuth forward / reverse request
//   az_phase, el_phase : coil drive, one-hot or 0000
//   az_pos, el_pos     : step positions
//   az_lim, el_lim     : request blocked by soft limit this cycle
//   busy               : either axis in RUN
module solar_stepper_drv
   import solar_pkg::*;
#(
   parameter int unsigned DEB_CYC  = 4,
   parameter int unsigned STEP_DIV = 8,
   parameter int unsigned HOLD_CYC = 16,
   parameter int unsigned POS_W    = 8,
   parameter int unsigned POS_MAX  = 200,
   parameter int unsigned POS_HOME = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mn,
   input  logic             ms,
   input  logic             me,
   input  logic             mw,
   output logic [3:0]       az_phase,
   output logic [3:0]       el_phase,
   output logic [POS_W-1:0] az_pos,
   output logic [POS_W-1:0] el_pos,
   output logic             az_lim,
   output logic             el_lim,
   output logic             busy
);

   logic az_run_nxt, el_run_nxt;
   logic busy_q, busy_d;

   stepper_axis #(
      .DEB_CYC (DEB_CYC),
      .STEP_DIV(STEP_DIV),
      .HOLD_CYC(HOLD_CYC),
      .POS_W   (POS_W),
      .POS_MAX (POS_MAX),
      .POS_HOME(POS_HOME)
   ) u_az (
      .clk    (clk),
      .rst    (rst),
      .fwd    (me),
      .rev    (mw),
      .phase  (az_phase),
      .pos    (az_pos),
      .lim    (az_lim),
      .run_nxt(az_run_nxt)
   );

   stepper_axis #(
      .DEB_CYC (DEB_CYC),
      .STEP_DIV(STEP_DIV),
      .HOLD_CYC(HOLD_CYC),
      .POS_W   (POS_W),
      .POS_MAX (POS_MAX),
      .POS_HOME(POS_HOME)
   ) u_el (
      .clk    (clk),
      .rst    (rst),
      .fwd    (mn),
      .rev    (ms),
      .phase  (el_phase),
      .pos    (el_pos),
      .lim    (el_lim),
      .run_nxt(el_run_nxt)
   );

   // Registered from next-state so busy lines up with the RUN state flops.
   always_comb begin
      busy_d = az_run_nxt | el_run_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= 1'b0;
      else     busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_solar_stepper_drv.sv
module tb_solar_stepper_drv;

   logic       clk = 1'b0;
   logic       rst, mn, ms, me, mw;
   logic [3:0] az_phase, el_phase;
   logic [7:0] az_pos, el_pos;
   logic       az_lim, el_lim, busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   solar_stepper_drv #(
      .DEB_CYC (4),
      .STEP_DIV(8),
      .HOLD_CYC(16),
      .POS_W   (8),
      .POS_MAX (200),
      .POS_HOME(100)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .mn      (mn),
      .ms      (ms),
      .me      (me),
      .mw      (mw),
      .az_phase(az_phase),
      .el_phase(el_phase),
      .az_pos  (az_pos),
      .el_pos  (el_pos),
      .az_lim  (az_lim),
      .el_lim  (el_lim),
      .busy    (busy)
   );

   typedef struct {
      logic       rst, mn, ms, me, mw;
      int         n;
      logic [3:0] ap, ep;
      logic [7:0] apos, epos;
      logic       al, el, bsy;
   } vec_t;

   vec_t vecs[31];

   function automatic vec_t mk(input logic r, input logic n_, input logic s_, input logic e_,
                               input logic w_, input int cyc, input logic [3:0] ap,
                               input logic [3:0] ep, input logic [7:0] apos,
                               input logic [7:0] epos, input logic al, input logic el,
                               input logic bsy);
      vec_t v;
      v.rst = r; v.mn = n_; v.ms = s_; v.me = e_; v.mw = w_; v.n = cyc;
      v.ap = ap; v.ep = ep; v.apos = apos; v.epos = epos;
      v.al = al; v.el = el; v.bsy = bsy;
      return v;
   endfunction

   task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got ap=%b ep=%b apos=%0d epos=%0d al=%b el=%b busy=%b, exp ap=%b ep=%b apos=%0d epos=%0d al=%b el=%b busy=%b",
                  name, got[26:23], got[22:19], got[18:11], got[10:3], got[2], got[1], got[0],
                  exp[26:23], exp[22:19], exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [26:0] outs();
      return {az_phase, el_phase, az_pos, el_pos, az_lim, el_lim, busy};
   endfunction

   initial begin
      //               rst mn ms me mw  cyc   ap       ep       apos epos al el busy
      vecs[0]  = mk(1, 0, 0, 0, 0,   1, 4'b0000, 4'b0000, 100, 100, 0, 0, 0); // reset
      vecs[1]  = mk(0, 0, 0, 0, 0,  50, 4'b0000, 4'b0000, 100, 100, 0, 0, 0); // idle
      vecs[2]  = mk(0, 0, 0, 1, 0,   3, 4'b0000, 4'b0000, 100, 100, 0, 0, 0); // debouncing
      vecs[3]  = mk(0, 0, 0, 1, 0,   1, 4'b0001, 4'b0000, 100, 100, 0, 0, 1); // edge 4: RUN
      vecs[4]  = mk(0, 0, 0, 1, 0,   7, 4'b0001, 4'b0000, 100, 100, 0, 0, 1);
      vecs[5]  = mk(0, 0, 0, 1, 0,   1, 4'b0010, 4'b0000, 101, 100, 0, 0, 1); // first step
      vecs[6]  = mk(0, 0, 0, 1, 0,   8, 4'b0100, 4'b0000, 102, 100, 0, 0, 1);
      vecs[7]  = mk(0, 0, 0, 0, 0,   1, 4'b0100, 4'b0000, 102, 100, 0, 0, 0); // HOLD
      vecs[8]  = mk(0, 0, 0, 0, 0,  15, 4'b0100, 4'b0000, 102, 100, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0,   1, 4'b0000, 4'b0000, 102, 100, 0, 0, 0); // coils off
      vecs[10] = mk(0, 0, 0, 1, 0,   4, 4'b0100, 4'b0000, 102, 100, 0, 0, 1);
      vecs[11] = mk(0, 0, 0, 1, 0,   8, 4'b1000, 4'b0000, 103, 100, 0, 0, 1);
      vecs[12] = mk(0, 0, 0, 0, 0,   5, 4'b1000, 4'b0000, 103, 100, 0, 0, 0); // HOLD
      vecs[13] = mk(0, 0, 0, 1, 0,   1, 4'b1000, 4'b0000, 103, 100, 0, 0, 0); // re-debounce, coils on
      vecs[14] = mk(0, 0, 0, 1, 0,   3, 4'b1000, 4'b0000, 103, 100, 0, 0, 1);
      vecs[15] = mk(0, 0, 0, 1, 0,   8, 4'b0001, 4'b0000, 104, 100, 0, 0, 1); // idx wraps 3->0
      vecs[16] = mk(0, 1, 1, 1, 0, 100, 4'b0001, 4'b0000, 116, 100, 0, 0, 1); // el conflict
      vecs[17] = mk(0, 0, 0, 1, 0, 668, 4'b0001, 4'b0000, 200, 100, 0, 0, 1); // reach limit
      vecs[18] = mk(0, 0, 0, 1, 0,   1, 4'b0001, 4'b0000, 200, 100, 1, 0, 1); // blocked
      vecs[19] = mk(0, 0, 0, 1, 0,  20, 4'b0001, 4'b0000, 200, 100, 1, 0, 1);
      vecs[20] = mk(0, 0, 0, 0, 1,   1, 4'b0001, 4'b0000, 200, 100, 0, 0, 0); // reverse -> DEB
      vecs[21] = mk(0, 0, 0, 0, 1,   3, 4'b0001, 4'b0000, 200, 100, 0, 0, 1);
      vecs[22] = mk(0, 0, 0, 0, 1,   8, 4'b1000, 4'b0000, 199, 100, 0, 0, 1); // off the limit
      vecs[23] = mk(1, 0, 0, 0, 0,   1, 4'b0000, 4'b0000, 100, 100, 0, 0, 0);
      vecs[24] = mk(0, 0, 0, 1, 0,  28, 4'b1000, 4'b0000, 103, 100, 0, 0, 1);
      vecs[25] = mk(1, 0, 0, 1, 0,   1, 4'b0000, 4'b0000, 100, 100, 0, 0, 0); // reset mid-RUN
      vecs[26] = mk(0, 0, 0, 0, 0,   2, 4'b0000, 4'b0000, 100, 100, 0, 0, 0);
      vecs[27] = mk(0, 1, 0, 0, 0,  12, 4'b0000, 4'b0010, 100, 101, 0, 0, 1); // elevation fwd
      vecs[28] = mk(0, 0, 1, 0, 0,   1, 4'b0000, 4'b0010, 100, 101, 0, 0, 0);
      vecs[29] = mk(0, 0, 1, 0, 0,   3, 4'b0000, 4'b0010, 100, 101, 0, 0, 1);
      vecs[30] = mk(0, 0, 1, 0, 0,   8, 4'b0000, 4'b0001, 100, 100, 0, 0, 1);

      rst = 1'b1; mn = 1'b0; ms = 1'b0; me = 1'b0; mw = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 31; i++) begin
         rst = vecs[i].rst; mn = vecs[i].mn; ms = vecs[i].ms;
         me = vecs[i].me;   mw = vecs[i].mw;
         repeat (vecs[i].n) @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), outs(),
               {vecs[i].ap, vecs[i].ep, vecs[i].apos, vecs[i].epos,
                vecs[i].al, vecs[i].el, vecs[i].bsy});
      end

      // Idle after reset: outputs must stay quiet every cycle.
      rst = 1'b1; mn = 1'b0; ms = 1'b0; me = 1'b0; mw = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("idle_c%0d", c), outs(),
               {4'b0000, 4'b0000, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0});
      end

      // Azimuth conflict (me=mw=1) must never move or energize.
      me = 1'b1; mw = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("az_conflict_c%0d", c), outs(),
               {4'b0000, 4'b0000, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0});
      end

      // Short request bursts below the debounce length never reach RUN.
      me = 1'b0; mw = 1'b0;
      for (int c = 0; c < 4; c++) begin
         mn = 1'b1;
         repeat (3) @(posedge clk);
         @(negedge clk);
         mn = 1'b0;
         @(posedge clk); @(negedge clk);
         check($sformatf("el_glitch_%0d", c), outs(),
               {4'b0000, 4'b0000, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
